// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions used by the receiver and transmitter
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx line synchroniser and three-sample majority vote
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_in_i,
    input  logic [PRESCALE_W-1:0] edge_cnt_i,
    input  logic [PRESCALE_W-1:0] half_prescale_i,
    output logic                  rx_s_o,
    output logic                  sampled_bit_o,
    output logic                  vote_done_o
);

    logic                  sync1_q;
    logic                  rx_s_q;
    logic                  s0_q;
    logic                  s1_q;
    logic                  bit_q;
    logic                  done_q;
    logic [PRESCALE_W-1:0] half_m1;
    logic [PRESCALE_W-1:0] half_p1;

    assign half_m1 = half_prescale_i - PRESCALE_W'(1);
    assign half_p1 = half_prescale_i + PRESCALE_W'(1);

    // Third sample is taken live from rx_s in the same cycle the vote is registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            bit_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            sync1_q <= rx_in_i;
            rx_s_q  <= sync1_q;
            done_q  <= 1'b0;
            if (edge_cnt_i == half_m1) begin
                s0_q <= rx_s_q;
            end
            if (edge_cnt_i == half_prescale_i) begin
                s1_q <= rx_s_q;
            end
            if (edge_cnt_i == half_p1) begin
                bit_q  <= majority3(s0_q, s1_q, rx_s_q);
                done_q <= 1'b1;
            end
        end
    end

    assign rx_s_o        = rx_s_q;
    assign sampled_bit_o = bit_q;
    assign vote_done_o   = done_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver with parity and stop checking
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rx_in_i,
    input  logic                  par_en_i,
    input  logic                  par_typ_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic [DATA_WIDTH-1:0] p_data_o,
    output logic                  data_valid_o,
    output logic                  par_err_o,
    output logic                  stop_err_o,
    output logic                  busy_o
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    uart_state_e           state_q;
    logic [PRESCALE_W-1:0] edge_cnt_q;
    logic [PRESCALE_W-1:0] edge_cnt_d;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [PRESCALE_W-1:0] half_prescale;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_flag_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stop_err_q;
    logic                  busy_q;
    logic                  edge_last;
    logic                  exp_par;
    logic                  rx_s;
    logic                  sampled_bit;
    logic                  vote_done;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .rx_in_i         (rx_in_i),
        .edge_cnt_i      (edge_cnt_q),
        .half_prescale_i (half_prescale),
        .rx_s_o          (rx_s),
        .sampled_bit_o   (sampled_bit),
        .vote_done_o     (vote_done)
    );

    assign half_prescale = prescale_q >> 1;
    assign edge_last     = (edge_cnt_q == (prescale_q - PRESCALE_W'(1)));
    assign exp_par       = (^shift_q) ^ (par_typ_q == PAR_ODD);
    assign edge_cnt_d    = ((state_q == ST_IDLE) || edge_last) ? '0
                                                               : edge_cnt_q + PRESCALE_W'(1);

    // Every exit to IDLE clears edge_cnt so a start edge seen in that IDLE cycle begins at 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            edge_cnt_q   <= '0;
            prescale_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_flag_q   <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
            edge_cnt_q   <= edge_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_q    <= ST_START;
                        busy_q     <= 1'b1;
                        par_en_q   <= par_en_i;
                        par_typ_q  <= par_typ_i;
                        prescale_q <= prescale_i;
                        par_flag_q <= 1'b0;
                        bit_cnt_q  <= '0;
                    end
                end
                ST_START: begin
                    if (vote_done && sampled_bit) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        edge_cnt_q <= '0;
                    end else if (edge_last) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (vote_done) begin
                        shift_q[bit_cnt_q] <= sampled_bit;
                    end
                    if (edge_last) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            state_q <= par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (vote_done && (sampled_bit != exp_par)) begin
                        par_flag_q <= 1'b1;
                    end
                    if (edge_last) begin
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (vote_done) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        edge_cnt_q <= '0;
                        if (!sampled_bit) begin
                            stop_err_q <= 1'b1;
                        end else if (par_flag_q) begin
                            par_err_q <= 1'b1;
                        end else begin
                            p_data_q     <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                    end else if (edge_last) begin
                        // Only reachable with a prescale too small to ever vote.
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        edge_cnt_q <= '0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    edge_cnt_q <= '0;
                end
            endcase
        end
    end

    assign p_data_o     = p_data_q;
    assign data_valid_o = data_valid_q;
    assign par_err_o    = par_err_q;
    assign stop_err_o   = stop_err_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed vector bench for uart_rx
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       pe;
    logic       pt;
    logic [5:0] ps;
    logic [7:0] p_data;
    logic       dv;
    logic       perr;
    logic       serr;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .rx_in_i      (rx),
        .par_en_i     (pe),
        .par_typ_i    (pt),
        .prescale_i   (ps),
        .p_data_o     (p_data),
        .data_valid_o (dv),
        .par_err_o    (perr),
        .stop_err_o   (serr),
        .busy_o       (busy)
    );

    int         n_vec = 0;
    int         n_bad = 0;
    int         dv_cnt = 0;
    int         pe_cnt = 0;
    int         se_cnt = 0;
    logic [7:0] dv_hist[$];

    always @(negedge clk) begin
        if (dv) begin
            dv_cnt <= dv_cnt + 1;
            dv_hist.push_back(p_data);
        end
        if (perr) pe_cnt <= pe_cnt + 1;
        if (serr) se_cnt <= se_cnt + 1;
    end

    typedef struct {
        int         p;
        bit         pen;
        bit         ptyp;
        logic [7:0] data;
        bit         pbit;
        bit         sbit;
        int         e_dv;
        int         e_pe;
        int         e_se;
        logic [7:0] e_pd;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                              input bit sbit, input int p, input int slots);
        logic seq[11];
        int   n;
        seq[0] = 1'b0;
        for (int i = 0; i < 8; i++) seq[i+1] = d[i];
        n = 9;
        if (pen) begin
            seq[n] = pbit;
            n++;
        end
        seq[n] = sbit;
        n++;
        for (int i = 0; i < n && i < slots; i++) begin
            rx = seq[i];
            repeat (p) @(negedge clk);
        end
    endtask

    task automatic idle(input int cycles);
        rx = 1'b1;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int  dv0, pe0, se0;
        bit  seen;

        vecs[0] = '{16, 0, 0, 8'hA5, 0, 1, 1, 0, 0, 8'hA5};
        vecs[1] = '{ 8, 1, 0, 8'h3C, 0, 1, 1, 0, 0, 8'h3C};
        vecs[2] = '{ 8, 1, 0, 8'h3C, 1, 1, 0, 1, 0, 8'h3C};
        vecs[3] = '{16, 1, 1, 8'h01, 0, 0, 0, 0, 1, 8'h3C};
        vecs[4] = '{16, 1, 1, 8'h01, 0, 1, 1, 0, 0, 8'h01};
        vecs[5] = '{10, 0, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00};
        vecs[6] = '{ 8, 1, 1, 8'hFF, 1, 1, 1, 0, 0, 8'hFF};
        vecs[7] = '{62, 0, 0, 8'h81, 0, 1, 1, 0, 0, 8'h81};

        rst_n = 1'b0;
        rx    = 1'b1;
        pe    = 1'b0;
        pt    = 1'b0;
        ps    = 6'd16;
        repeat (3) @(negedge clk);
        check("reset p_data", 32'(p_data), 32'h0);
        check("reset data_valid", 32'(dv), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset errs", {30'b0, perr, serr}, 32'h0);
        rst_n = 1'b1;
        idle(5);

        for (int v = 0; v < 8; v++) begin
            ps = 6'(vecs[v].p);
            pe = vecs[v].pen;
            pt = vecs[v].ptyp;
            dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
            send_frame(vecs[v].data, vecs[v].pen, vecs[v].pbit, vecs[v].sbit, vecs[v].p, 99);
            idle(2 * vecs[v].p + 10);
            check($sformatf("vec%0d data_valid count", v), 32'(dv_cnt - dv0), 32'(vecs[v].e_dv));
            check($sformatf("vec%0d par_err count", v), 32'(pe_cnt - pe0), 32'(vecs[v].e_pe));
            check($sformatf("vec%0d stop_err count", v), 32'(se_cnt - se0), 32'(vecs[v].e_se));
            check($sformatf("vec%0d p_data", v), 32'(p_data), 32'(vecs[v].e_pd));
            check($sformatf("vec%0d busy after", v), 32'(busy), 32'h0);
        end

        // short low glitch from idle
        ps = 6'd16; pe = 1'b0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (busy) seen = 1'b1;
            @(negedge clk);
        end
        check("glitch busy rose", 32'(seen), 32'h1);
        idle(40);
        check("glitch busy fell", 32'(busy), 32'h0);
        check("glitch no pulses", 32'((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0)), 32'h0);
        check("glitch p_data held", 32'(p_data), 32'h81);

        // back-to-back frames
        ps = 6'd32; pe = 1'b0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8'h55, 0, 0, 1, 32, 99);
        send_frame(8'hAA, 0, 0, 1, 32, 99);
        idle(80);
        check("b2b data_valid count", 32'(dv_cnt - dv0), 32'h2);
        check("b2b error count", 32'((pe_cnt - pe0) + (se_cnt - se0)), 32'h0);
        if (dv_cnt - dv0 == 2) begin
            check("b2b first byte", 32'(dv_hist[dv_hist.size()-2]), 32'h55);
            check("b2b second byte", 32'(dv_hist[dv_hist.size()-1]), 32'hAA);
        end

        // break: line held low until stop_err, then released
        ps = 6'd16; pe = 1'b0;
        dv0 = dv_cnt; se0 = se_cnt;
        rx = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (serr) seen = 1'b1;
        end
        check("break stop_err seen", 32'(seen), 32'h1);
        idle(60);
        check("break stop_err count", 32'(se_cnt - se0), 32'h1);
        check("break no data_valid", 32'(dv_cnt - dv0), 32'h0);
        check("break busy fell", 32'(busy), 32'h0);
        send_frame(8'h42, 0, 0, 1, 16, 99);
        idle(42);
        check("after break p_data", 32'(p_data), 32'h42);
        check("after break data_valid", 32'(dv_cnt - dv0), 32'h1);

        // reset during data bit 4
        dv0 = dv_cnt;
        send_frame(8'h3B, 0, 0, 1, 16, 5);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid-frame reset busy", 32'(busy), 32'h0);
        check("mid-frame reset p_data", 32'(p_data), 32'h0);
        check("mid-frame reset data_valid", 32'(dv), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(40);
        check("reset frame aborted", 32'(dv_cnt - dv0), 32'h0);
        send_frame(8'h7E, 0, 0, 1, 16, 99);
        idle(42);
        check("post-reset data_valid", 32'(dv_cnt - dv0), 32'h1);
        check("post-reset p_data", 32'(p_data), 32'h7E);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
